// File: rtl/rotate_cmd_sequencer.sv
// Command front end for the barrel rotator: expands each accepted rotate command into
// cmd_count+1 registered beats whose amount advances by the step modulo DATA_WIDTH.
module rotate_cmd_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic [SHIFT_WIDTH-1:0] cmd_amount,
  input  logic [SHIFT_WIDTH-1:0] cmd_step,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   cmd_direction,
  output logic                   rot_valid,
  input  logic                   rot_ready,
  output logic [DATA_WIDTH-1:0]  rot_data,
  output logic [SHIFT_WIDTH-1:0] rot_amount,
  output logic                   rot_direction,
  output logic                   rot_last
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [SHIFT_WIDTH:0] DW_EXT = (SHIFT_WIDTH+1)'(DATA_WIDTH);

  state_t                 state;
  logic [SHIFT_WIDTH-1:0] step_q;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   accept;

  // A single conditional subtract is enough because 2^SHIFT_WIDTH < 2*DATA_WIDTH.
  function automatic logic [SHIFT_WIDTH-1:0] wrap_amount(input logic [SHIFT_WIDTH:0] x);
    logic [SHIFT_WIDTH:0] r;
    r = (x >= DW_EXT) ? x - DW_EXT : x;
    return r[SHIFT_WIDTH-1:0];
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] norm_amount(input logic [SHIFT_WIDTH-1:0] x);
    return wrap_amount({1'b0, x});
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] advance_amount(input logic [SHIFT_WIDTH-1:0] a,
                                                            input logic [SHIFT_WIDTH-1:0] s);
    return wrap_amount({1'b0, a} + {1'b0, s});
  endfunction

  assign cmd_ready = !flush && ((state == IDLE) || (rot_last && rot_ready));
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rot_valid     <= 1'b0;
      rot_last      <= 1'b0;
      rot_data      <= '0;
      rot_amount    <= '0;
      rot_direction <= 1'b0;
      step_q        <= '0;
      remaining     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      rot_valid <= 1'b0;
      rot_last  <= 1'b0;
    end else if (accept) begin
      // Also covers the back-to-back load on the last beat of the previous command.
      state         <= ISSUE;
      rot_valid     <= 1'b1;
      rot_data      <= cmd_data;
      rot_amount    <= norm_amount(cmd_amount);
      rot_direction <= cmd_direction;
      step_q        <= norm_amount(cmd_step);
      remaining     <= cmd_count;
      rot_last      <= (cmd_count == '0);
    end else if (state == ISSUE && rot_ready) begin
      if (rot_last) begin
        state     <= IDLE;
        rot_valid <= 1'b0;
        rot_last  <= 1'b0;
      end else begin
        remaining  <= remaining - 1'b1;
        rot_amount <= advance_amount(rot_amount, step_q);
        rot_last   <= (remaining == COUNT_WIDTH'(1));
      end
    end
  end

endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Bench for rotate_cmd_sequencer: a queue-based beat model checks every cycle of a
// DATA_WIDTH=32 instance; a second DATA_WIDTH=24 instance exercises non-power-of-two wrap.
module tb_rotate_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [4:0]  cmd_amount;
  logic [4:0]  cmd_step;
  logic [7:0]  cmd_count;
  logic        cmd_direction;
  logic        rot_valid;
  logic        rot_ready;
  logic [31:0] rot_data;
  logic [4:0]  rot_amount;
  logic        rot_direction;
  logic        rot_last;

  logic        b_flush;
  logic        b_cmd_valid;
  logic        b_cmd_ready;
  logic [23:0] b_cmd_data;
  logic [4:0]  b_cmd_amount;
  logic [4:0]  b_cmd_step;
  logic [7:0]  b_cmd_count;
  logic        b_cmd_direction;
  logic        b_rot_valid;
  logic        b_rot_ready;
  logic [23:0] b_rot_data;
  logic [4:0]  b_rot_amount;
  logic        b_rot_direction;
  logic        b_rot_last;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rotate_cmd_sequencer #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_amount(cmd_amount), .cmd_step(cmd_step), .cmd_count(cmd_count),
    .cmd_direction(cmd_direction),
    .rot_valid(rot_valid), .rot_ready(rot_ready), .rot_data(rot_data),
    .rot_amount(rot_amount), .rot_direction(rot_direction), .rot_last(rot_last)
  );

  rotate_cmd_sequencer #(.DATA_WIDTH(24), .COUNT_WIDTH(8)) dut24 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_data(b_cmd_data),
    .cmd_amount(b_cmd_amount), .cmd_step(b_cmd_step), .cmd_count(b_cmd_count),
    .cmd_direction(b_cmd_direction),
    .rot_valid(b_rot_valid), .rot_ready(b_rot_ready), .rot_data(b_rot_data),
    .rot_amount(b_rot_amount), .rot_direction(b_rot_direction), .rot_last(b_rot_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of the command in flight, oldest first.
  typedef struct {
    logic [31:0] d;
    int          a;
    logic        dir;
    logic        last;
  } beat_t;

  beat_t       q[$];
  bit          stalled = 0;
  logic [31:0] prev_data;
  logic [4:0]  prev_amount;
  logic        prev_dir;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 0;
    end else begin
      check("cmd_ready", cmd_ready,
            !flush && (q.size() == 0 || (q.size() == 1 && rot_ready)));
      check("rot_valid", rot_valid, q.size() != 0);
      if (stalled && rot_valid) begin
        check("stall_data", rot_data, prev_data);
        check("stall_amount", rot_amount, prev_amount);
        check("stall_dir", rot_direction, prev_dir);
        check("stall_last", rot_last, prev_last);
      end
      if (rot_valid && q.size() != 0) begin
        check("beat_data", rot_data, q[0].d);
        check("beat_amount", rot_amount, q[0].a);
        check("beat_dir", rot_direction, q[0].dir);
        check("beat_last", rot_last, q[0].last);
        if (rot_ready) void'(q.pop_front());
      end
      stalled     = rot_valid && !rot_ready && !flush;
      prev_data   = rot_data;
      prev_amount = rot_amount;
      prev_dir    = rot_direction;
      prev_last   = rot_last;
      if (flush) q.delete();
      if (cmd_valid && cmd_ready) begin
        for (int k = 0; k <= int'(cmd_count); k++) begin
          beat_t b;
          b.d    = cmd_data;
          b.a    = (int'(cmd_amount) + k * int'(cmd_step)) % 32;
          b.dir  = cmd_direction;
          b.last = (k == int'(cmd_count));
          q.push_back(b);
        end
      end
    end
  end

  // Callers are always positioned 1 time unit after a rising edge.
  task automatic send_cmd(input logic [31:0] d, input logic [4:0] a, input logic [4:0] s,
                          input logic [7:0] c, input logic dir, input bit rnd);
    bit ok = 0;
    cmd_data = d; cmd_amount = a; cmd_step = s; cmd_count = c; cmd_direction = dir;
    cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
      @(posedge clk); #1;
      if (rnd) rot_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (rnd) rot_ready = 1'($urandom_range(0, 1));
    if (!ok) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic drain(input bit rnd);
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      done = (q.size() == 0) && !rot_valid;
      @(posedge clk); #1;
      if (done) break;
      if (rnd) rot_ready = 1'($urandom_range(0, 1));
    end
    rot_ready = 1'b1;
    if (!done) check("drain_timeout", 0, 1);
  endtask

  int exp_a[8] = '{3, 8, 13, 18, 23, 28, 1, 6};

  initial begin
    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; rot_ready = 1'b1;
    cmd_data = '0; cmd_amount = '0; cmd_step = '0; cmd_count = '0; cmd_direction = 1'b0;
    b_flush = 1'b0; b_cmd_valid = 1'b0; b_rot_ready = 1'b1; b_cmd_data = '0;
    b_cmd_amount = '0; b_cmd_step = '0; b_cmd_count = '0; b_cmd_direction = 1'b0;

    #1;
    check("reset_rot_valid", rot_valid, 0);
    check("reset_rot_last", rot_last, 0);
    check("reset_rot_data", rot_data, 0);
    check("reset_rot_amount", rot_amount, 0);
    check("reset_rot_direction", rot_direction, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", cmd_ready, 1);

    // Amount sequence 3,8,...,6 with rot_last only on the eighth beat.
    send_cmd(32'hDEADBEEF, 5'd3, 5'd5, 8'd7, 1'b1, 0);
    for (int k = 0; k < 8; k++) begin
      check("seq_valid", rot_valid, 1);
      check("seq_amount", rot_amount, exp_a[k]);
      check("seq_last", rot_last, k == 7);
      check("seq_dir", rot_direction, 1);
      @(posedge clk); #1;
    end
    check("seq_done_valid", rot_valid, 0);
    drain(0);

    // Backpressure on a four-beat command.
    rot_ready = 1'b0;
    send_cmd($urandom, 5'($urandom), 5'($urandom), 8'd3, 1'($urandom), 1);
    drain(1);

    // Back-to-back: second command lands on the last beat of the first.
    send_cmd(32'h11112222, 5'd10, 5'd1, 8'd2, 1'b0, 0);
    for (int i = 0; i < 10 && !(rot_valid && rot_last); i++) begin
      @(posedge clk); #1;
    end
    send_cmd(32'h33334444, 5'd20, 5'd2, 8'd1, 1'b1, 0);
    check("b2b_valid", rot_valid, 1);
    check("b2b_amount", rot_amount, 20);
    check("b2b_data", rot_data, 32'h33334444);
    check("b2b_last", rot_last, 0);
    drain(0);

    // Flush on beat 2 of a count=5 command, then a fresh command.
    send_cmd(32'hA5A5A5A5, 5'd4, 5'd9, 8'd5, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_flush_amount", rot_amount, 22);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", rot_valid, 0);
    check("flush_last", rot_last, 0);
    send_cmd(32'h0F0F0F0F, 5'd17, 5'd30, 8'd1, 1'b1, 0);
    check("after_flush_amount", rot_amount, 17);
    check("after_flush_last", rot_last, 0);
    drain(0);

    // Maximum count and a few random commands under random backpressure.
    send_cmd($urandom, 5'($urandom), 5'($urandom), 8'd255, 1'($urandom), 1);
    drain(1);
    for (int n = 0; n < 6; n++) begin
      send_cmd($urandom, 5'($urandom), 5'($urandom), 8'($urandom_range(0, 9)),
               1'($urandom), 1);
    end
    drain(1);

    // Asynchronous reset in the middle of a command.
    send_cmd(32'hCAFEF00D, 5'd7, 5'd3, 8'd7, 1'b1, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", rot_valid, 0);
    check("async_rst_amount", rot_amount, 0);
    check("async_rst_last", rot_last, 0);
    check("async_rst_data", rot_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", cmd_ready, 1);
    check("rst_release_valid", rot_valid, 0);
    @(posedge clk); #1;

    // DATA_WIDTH=24: amount 30, step 31 -> 6, 13, 20, 3.
    b_cmd_data = 24'hABCDEF; b_cmd_amount = 5'd30; b_cmd_step = 5'd31;
    b_cmd_count = 8'd3; b_cmd_direction = 1'b1; b_cmd_valid = 1'b1;
    @(negedge clk);
    check("dw24_cmd_ready", b_cmd_ready, 1);
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("dw24_valid", b_rot_valid, 1);
      check("dw24_amount", b_rot_amount, (30 % 24 + k * (31 % 24)) % 24);
      check("dw24_last", b_rot_last, k == 3);
      check("dw24_data", b_rot_data, 24'hABCDEF);
      @(posedge clk); #1;
    end
    check("dw24_done_valid", b_rot_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
